// File: rtl/sysarr_mem_arbiter.sv
// Round-robin arbiter sharing the single systolic-array RAM port among the
// matmul FSM, output writer and STW loader, with burst lock and read-return routing.
module sysarr_mem_arbiter #(
  parameter int NUM_REQ            = 3,
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 64,
  parameter int MEM_ACCESS_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wr_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          mem_en,
  output logic                          mem_wr_en,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wr_data,
  input  logic [DATA_WIDTH-1:0]         mem_rd_data,
  output logic                          busy
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TRK_N = MEM_ACCESS_LATENCY + 1;

  logic [ID_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic                        lock_valid_q, lock_valid_d;
  logic [ID_W-1:0]             lock_id_q, lock_id_d;
  logic                        mem_en_q, mem_en_d;
  logic                        mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]       mem_wr_data_q, mem_wr_data_d;
  logic [TRK_N-1:0]            trk_vld_q, trk_vld_d;
  logic [TRK_N-1:0][ID_W-1:0]  trk_id_q, trk_id_d;

  logic [NUM_REQ-1:0] hi_mask_s, hi_req_s, pick_req_s;
  logic               lock_hold_s;
  logic               gnt_any_s;
  logic [ID_W-1:0]    gnt_idx_s;

  // Requests at or above the pointer win; otherwise wrap to the lowest request.
  always_comb begin
    hi_mask_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask_s[i] = (i >= int'(rr_ptr_q));
    end
    hi_req_s    = req & hi_mask_s;
    pick_req_s  = (|hi_req_s) ? hi_req_s : req;
    lock_hold_s = lock_valid_q && req[lock_id_q] && req_lock[lock_id_q];
    gnt_idx_s   = '0;
    gnt_any_s   = 1'b0;
    if (lock_hold_s) begin
      gnt_any_s = 1'b1;
      gnt_idx_s = lock_id_q;
    end else begin
      gnt_any_s = |pick_req_s;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        gnt_idx_s = pick_req_s[i] ? ID_W'(i) : gnt_idx_s;
      end
    end
    if (!rst) begin
      gnt_any_s = 1'b0;
    end else begin
      gnt_any_s = gnt_any_s;
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any_s) begin
      gnt[gnt_idx_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    lock_valid_d  = 1'b0;
    lock_id_d     = lock_id_q;
    mem_en_d      = gnt_any_s;
    mem_wr_en_d   = mem_wr_en_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    if (gnt_any_s) begin
      // Pointer already sits at k+1 while a lock is held, so release resumes there.
      rr_ptr_d      = (gnt_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + 1'b1;
      lock_valid_d  = req_lock[gnt_idx_s];
      lock_id_d     = gnt_idx_s;
      mem_wr_en_d   = req_wr_en[gnt_idx_s];
      mem_addr_d    = req_addr[gnt_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wr_data_d = req_wr_data[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      lock_valid_d  = 1'b0;
    end
    trk_vld_d[0] = gnt_any_s && !req_wr_en[gnt_idx_s];
    trk_id_d[0]  = gnt_idx_s;
    for (int s = 1; s < TRK_N; s++) begin
      trk_vld_d[s] = trk_vld_q[s-1];
      trk_id_d[s]  = trk_id_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q      <= '0;
      lock_valid_q  <= 1'b0;
      lock_id_q     <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      trk_vld_q     <= '0;
      trk_id_q      <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      lock_valid_q  <= lock_valid_d;
      lock_id_q     <= lock_id_d;
      mem_en_q      <= mem_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      trk_vld_q     <= trk_vld_d;
      trk_id_q      <= trk_id_d;
    end
  end

  always_comb begin
    rd_valid = '0;
    if (rst && trk_vld_q[TRK_N-1]) begin
      rd_valid[trk_id_q[TRK_N-1]] = 1'b1;
    end else begin
      rd_valid = '0;
    end
  end

  assign rd_data     = mem_rd_data;
  assign mem_en      = mem_en_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = mem_en_q | (|trk_vld_q);

endmodule
